// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Optional unsigned support (multu/divu) is enabled by defining MULDIV_UNSIGNED_EN.
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam logic [31:0] MIN_INT = 32'h8000_0000;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MUL_ITER = 3'd1,
      DIV_ITER = 3'd2,
      FIX      = 3'd3,
      DONE     = 3'd4,
      DZ       = 3'd5
   } muldivStateT;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } opSelT;

   // States during which control must stall mfhi/mflo and new mult/div.
   function automatic logic isBusyState(input muldivStateT s);
      return (s == MUL_ITER) || (s == DIV_ITER) || (s == FIX) || (s == DZ);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Handshake/data bundle between main control, datapath and the muldiv unit.
// With MULDIV_UNSIGNED_EN defined the bundle also carries is_unsigned.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);

   logic             start_mult;
   logic             start_div;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             abort;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
`ifdef MULDIV_UNSIGNED_EN
   logic             is_unsigned;
`endif
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start_mult, start_div, op_a, op_b, abort, hi_we, lo_we, wdata,
`ifdef MULDIV_UNSIGNED_EN
      output is_unsigned,
`endif
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start_mult, start_div, op_a, op_b, abort, hi_we, lo_we, wdata,
`ifdef MULDIV_UNSIGNED_EN
      input  is_unsigned,
`endif
      output busy, done, div_zero, hi, lo
   );

endinterface

// File: rtl/muldiv_iter_counter.sv
// Iteration counter for the muldiv sequencer: loads WIDTH-1, counts down to 0.
module muldiv_iter_counter #(parameter int WIDTH = 32) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic dec,
   input  logic clear,
   output logic last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

   logic [CW-1:0] count;

   // Load has priority so a start accepted in the DONE cycle restarts cleanly.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (clear) begin
         count <= '0;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign last = (count == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: signed shift-add multiply, signed restoring divide.
// Define MULDIV_UNSIGNED_EN to add is_unsigned (multu/divu) on the bus.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic          clock,
   input logic          reset,
   muldiv_ctrl_if.slave bus
);

   muldivStateT      state, nextState;
   opSelT            opSel;
   logic             startAccept;
   logic             isUnsignedOp;
   logic             aNeg, bNeg;
   logic             negRes, negRem;
   logic             iterLast;
   logic             busyR, doneR, divZeroR;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] accHi, accLo;
   logic [WIDTH-1:0] hiR, loR;
   logic [WIDTH-1:0] fixHi, fixLo;
   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   divShift;
   logic [WIDTH+1:0] divDiff;
   logic [2*WIDTH-1:0] prodNeg;

`ifdef MULDIV_UNSIGNED_EN
   assign isUnsignedOp = bus.is_unsigned;
`else
   assign isUnsignedOp = 1'b0;
`endif

   assign aNeg = !isUnsignedOp && bus.op_a[WIDTH-1];
   assign bNeg = !isUnsignedOp && bus.op_b[WIDTH-1];

   muldiv_iter_counter #(.WIDTH(WIDTH)) iterCounter (
      .clock (clock),
      .reset (reset),
      .load  (startAccept),
      .dec   ((state == MUL_ITER) || (state == DIV_ITER)),
      .clear (bus.abort && (state != IDLE)),
      .last  (iterLast)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; DONE behaves like IDLE for accepting a new start, and abort beats start.
   always_comb begin
      nextState   = state;
      startAccept = 1'b0;
      case (state)
         IDLE, DONE: begin
            nextState = IDLE;
            if (!bus.abort && (bus.start_mult || bus.start_div)) begin
               startAccept = 1'b1;
               if (bus.start_mult) begin
                  nextState = MUL_ITER;
               end else if (bus.op_b == '0) begin
                  nextState = DZ;
               end else begin
                  nextState = DIV_ITER;
               end
            end
         end
         MUL_ITER, DIV_ITER: begin
            if (bus.abort) begin
               nextState = IDLE;
            end else if (iterLast) begin
               nextState = FIX;
            end
         end
         FIX: begin
            nextState = bus.abort ? IDLE : DONE;
         end
         DZ: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // One multiply step adds the multiplicand into HI when the LSB of LO is set, then shifts right.
   assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
   assign divShift = {accHi, accLo[WIDTH-1]};
   assign divDiff  = {1'b0, divShift} - {2'b00, opnd};
   assign prodNeg  = -{accHi, accLo};

   // Sign correction; MIN_INT / -1 falls out naturally as quotient 0x8000_0000, remainder 0.
   always_comb begin
      fixHi = accHi;
      fixLo = accLo;
      if (opSel == OP_MULT) begin
         if (negRes) begin
            {fixHi, fixLo} = prodNeg;
         end
      end else begin
         if (negRes) begin
            fixLo = -accLo;
         end
         if (negRem) begin
            fixHi = -accHi;
         end
      end
   end

   // Operand capture and iteration datapath: accHi is product-high / remainder, accLo is multiplier / quotient.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         opSel  <= OP_MULT;
         opnd   <= '0;
         accHi  <= '0;
         accLo  <= '0;
         negRes <= 1'b0;
         negRem <= 1'b0;
      end else if (startAccept) begin
         opSel  <= bus.start_mult ? OP_MULT : OP_DIV;
         opnd   <= bNeg ? -bus.op_b : bus.op_b;
         accHi  <= '0;
         accLo  <= aNeg ? -bus.op_a : bus.op_a;
         negRes <= aNeg ^ bNeg;
         negRem <= aNeg;
      end else if ((state == MUL_ITER) && !bus.abort) begin
         accHi <= mulSum[WIDTH:1];
         accLo <= {mulSum[0], accLo[WIDTH-1:1]};
      end else if ((state == DIV_ITER) && !bus.abort) begin
         accHi <= divDiff[WIDTH+1] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
         accLo <= {accLo[WIDTH-2:0], ~divDiff[WIDTH+1]};
      end
   end

   // HI/LO: result lands on the FIX->DONE edge; mthi/mtlo only while not busy.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hiR <= '0;
         loR <= '0;
      end else if ((state == FIX) && !bus.abort) begin
         hiR <= fixHi;
         loR <= fixLo;
      end else if (!busyR) begin
         if (bus.hi_we) begin
            hiR <= bus.wdata;
         end
         if (bus.lo_we) begin
            loR <= bus.wdata;
         end
      end
   end

   // Status flags are registered from the next state so they line up with it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busyR    <= 1'b0;
         doneR    <= 1'b0;
         divZeroR <= 1'b0;
      end else begin
         busyR    <= isBusyState(nextState);
         doneR    <= (nextState == DONE);
         divZeroR <= (nextState == DZ);
      end
   end

   assign bus.busy     = busyR;
   assign bus.done     = doneR;
   assign bus.div_zero = divZeroR;
   assign bus.hi       = hiR;
   assign bus.lo       = loR;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboard of expected HI/LO per accepted op.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } resultT;

   logic clock;
   logic reset;
   int   passCnt  = 0;
   int   totalCnt = 0;
   resultT sb[$];
   logic [31:0] modelHi, modelLo;

   muldiv_ctrl_if #(.WIDTH(32)) bus();

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic resultT modelMult(input logic [31:0] a, input logic [31:0] b);
      resultT r;
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      r.hi = p[63:32];
      r.lo = p[31:0];
      return r;
   endfunction

   function automatic resultT modelDiv(input logic [31:0] a, input logic [31:0] b);
      resultT r;
      longint q, m;
      q = longint'($signed(a)) / longint'($signed(b));
      m = longint'($signed(a)) % longint'($signed(b));
      r.lo = q[31:0];
      r.hi = m[31:0];
      return r;
   endfunction

   // Called at a falling edge; holds the start for one cycle and returns at the falling edge of T+1.
   task automatic pulseStart(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      bus.start_mult = m;
      bus.start_div  = d;
      bus.op_a       = a;
      bus.op_b       = b;
      @(negedge clock);
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
   endtask

   task automatic waitDone(output int cycles, output int busyLow);
      cycles  = 1;
      busyLow = 0;
      while ((bus.done !== 1'b1) && (cycles < 60)) begin
         if (bus.busy !== 1'b1) busyLow++;
         @(negedge clock);
         cycles++;
      end
   endtask

   task automatic applyStimulus(input logic hw, input logic lw, input logic [31:0] d);
      bus.hi_we = hw;
      bus.lo_we = lw;
      bus.wdata = d;
      @(negedge clock);
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clock);
      totalCnt++;
      if ({bus.busy, bus.done, bus.div_zero} !== 3'b000)
         $display("[TB] FAIL resetFlags: got %b expected 000", {bus.busy, bus.done, bus.div_zero});
      else passCnt++;
      totalCnt++;
      if ({bus.hi, bus.lo} !== 64'h0)
         $display("[TB] FAIL resetHiLo: got %h expected 0", {bus.hi, bus.lo});
      else passCnt++;
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_mult();
      int cyc, bl;
      resultT exp;
      sb.push_back(modelMult(32'd7, 32'hFFFF_FFFD));
      pulseStart(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      waitDone(cyc, bl);
      totalCnt++;
      if (cyc !== 34) $display("[TB] FAIL multLatency: got %0d expected 34", cyc); else passCnt++;
      totalCnt++;
      if (bl !== 0) $display("[TB] FAIL multBusy: busy low %0d cycles, expected 0", bl); else passCnt++;
      totalCnt++;
      if (bus.busy !== 1'b0) $display("[TB] FAIL multBusyDone: got %b expected 0", bus.busy); else passCnt++;
      exp = sb.pop_front();
      totalCnt++;
      if ({bus.hi, bus.lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB} || {bus.hi, bus.lo} !== exp)
         $display("[TB] FAIL multResult: got %h expected %h", {bus.hi, bus.lo}, exp);
      else passCnt++;
      @(negedge clock);
      totalCnt++;
      if (bus.done !== 1'b0) $display("[TB] FAIL multDonePulse: got %b expected 0", bus.done); else passCnt++;
   endtask

   task automatic test_div();
      int cyc, bl;
      resultT exp;
      sb.push_back(modelDiv(32'hFFFF_FFF9, 32'd2));
      pulseStart(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
      waitDone(cyc, bl);
      totalCnt++;
      if (cyc !== 34) $display("[TB] FAIL divLatency: got %0d expected 34", cyc); else passCnt++;
      exp = sb.pop_front();
      totalCnt++;
      if ({bus.hi, bus.lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || {bus.hi, bus.lo} !== exp)
         $display("[TB] FAIL divResult: got %h expected %h", {bus.hi, bus.lo}, exp);
      else passCnt++;
      modelHi = exp.hi;
      modelLo = exp.lo;
      @(negedge clock);
   endtask

   task automatic test_div_zero();
      int doneSeen = 0;
      applyStimulus(1'b1, 1'b0, 32'h1234);
      modelHi = 32'h1234;
      totalCnt++;
      if (bus.hi !== 32'h1234) $display("[TB] FAIL mthi: got %h expected 00001234", bus.hi); else passCnt++;
      pulseStart(1'b0, 1'b1, 32'd5, 32'd0);
      totalCnt++;
      if ({bus.div_zero, bus.busy, bus.done} !== 3'b110)
         $display("[TB] FAIL dzPulse: got %b expected 110", {bus.div_zero, bus.busy, bus.done});
      else passCnt++;
      @(negedge clock);
      totalCnt++;
      if ({bus.div_zero, bus.busy} !== 2'b00)
         $display("[TB] FAIL dzEnd: got %b expected 00", {bus.div_zero, bus.busy});
      else passCnt++;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1 || bus.div_zero === 1'b1) doneSeen++;
         @(negedge clock);
      end
      totalCnt++;
      if (doneSeen !== 0) $display("[TB] FAIL dzNoDone: got %0d pulses expected 0", doneSeen); else passCnt++;
      totalCnt++;
      if ({bus.hi, bus.lo} !== {modelHi, modelLo})
         $display("[TB] FAIL dzHold: got %h expected %h", {bus.hi, bus.lo}, {modelHi, modelLo});
      else passCnt++;
   endtask

   task automatic test_abort();
      int doneSeen = 0;
      pulseStart(1'b1, 1'b0, 32'd3, 32'd4);
      repeat (4) @(negedge clock);
      bus.hi_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
      pulseStart(1'b0, 1'b1, 32'd100, 32'd7);
      bus.hi_we = 1'b0;
      repeat (4) @(negedge clock);
      bus.abort = 1'b1;
      @(negedge clock);
      bus.abort = 1'b0;
      totalCnt++;
      if ({bus.busy, bus.done, bus.div_zero} !== 3'b000)
         $display("[TB] FAIL abortIdle: got %b expected 000", {bus.busy, bus.done, bus.div_zero});
      else passCnt++;
      totalCnt++;
      if ({bus.hi, bus.lo} !== {modelHi, modelLo})
         $display("[TB] FAIL abortHold: got %h expected %h", {bus.hi, bus.lo}, {modelHi, modelLo});
      else passCnt++;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) doneSeen++;
         @(negedge clock);
      end
      totalCnt++;
      if (doneSeen !== 0) $display("[TB] FAIL abortQuiet: got %0d active cycles expected 0", doneSeen); else passCnt++;
   endtask

   task automatic test_overflow_reset();
      int cyc, bl;
      resultT exp;
      sb.push_back(modelDiv(MIN_INT, 32'hFFFF_FFFF));
      pulseStart(1'b0, 1'b1, MIN_INT, 32'hFFFF_FFFF);
      waitDone(cyc, bl);
      totalCnt++;
      if (cyc !== 34) $display("[TB] FAIL ovfLatency: got %0d expected 34", cyc); else passCnt++;
      exp = sb.pop_front();
      totalCnt++;
      if ({bus.hi, bus.lo} !== {32'h0, MIN_INT} || {bus.hi, bus.lo} !== exp)
         $display("[TB] FAIL ovfResult: got %h expected %h", {bus.hi, bus.lo}, exp);
      else passCnt++;
      @(negedge clock);
      pulseStart(1'b1, 1'b0, 32'd5, 32'd5);
      repeat (5) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      totalCnt++;
      if ({bus.busy, bus.hi, bus.lo} !== 65'h0)
         $display("[TB] FAIL midOpReset: got busy=%b hi=%h lo=%h expected all 0", bus.busy, bus.hi, bus.lo);
      else passCnt++;
      @(negedge clock);
      reset = 1'b1;
      modelHi = 32'h0;
      modelLo = 32'h0;
      @(negedge clock);
   endtask

   task automatic test_both_start_lo_we();
      int cyc, bl;
      int doneSeen = 0;
      resultT exp;
      sb.push_back(modelMult(32'd6, 32'd7));
      pulseStart(1'b1, 1'b1, 32'd6, 32'd7);
      waitDone(cyc, bl);
      totalCnt++;
      if (cyc !== 34) $display("[TB] FAIL bothLatency: got %0d expected 34", cyc); else passCnt++;
      exp = sb.pop_front();
      totalCnt++;
      if ({bus.hi, bus.lo} !== {32'h0, 32'd42} || {bus.hi, bus.lo} !== exp)
         $display("[TB] FAIL bothResult: got %h expected %h", {bus.hi, bus.lo}, exp);
      else passCnt++;
      applyStimulus(1'b0, 1'b1, 32'd9);
      totalCnt++;
      if ({bus.hi, bus.lo} !== {32'h0, 32'd9})
         $display("[TB] FAIL mtloInDone: got %h expected %h", {bus.hi, bus.lo}, {32'h0, 32'd9});
      else passCnt++;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) doneSeen++;
         @(negedge clock);
      end
      totalCnt++;
      if (doneSeen !== 0) $display("[TB] FAIL divDropped: got %0d active cycles expected 0", doneSeen); else passCnt++;
   endtask

   task automatic test_back_to_back();
      int cyc, bl;
      resultT exp;
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      sb.push_back(modelMult(a, b));
      pulseStart(1'b1, 1'b0, a, b);
      for (int i = 0; i < 4; i++) begin
         waitDone(cyc, bl);
         totalCnt++;
         if (cyc !== 34) $display("[TB] FAIL b2bLatency%0d: got %0d expected 34", i, cyc); else passCnt++;
         exp = sb.pop_front();
         totalCnt++;
         if ({bus.hi, bus.lo} !== exp)
            $display("[TB] FAIL b2bResult%0d: got %h expected %h", i, {bus.hi, bus.lo}, exp);
         else passCnt++;
         if (i < 3) begin
            a = $urandom;
            b = $urandom;
            if (i == 1) b = b >> $urandom_range(31, 0);
            if (b == 32'h0) b = 32'd1;
            if (i[0] == 1'b0) begin
               sb.push_back(modelDiv(a, b));
               pulseStart(1'b0, 1'b1, a, b);
            end else begin
               sb.push_back(modelMult(a, b));
               pulseStart(1'b1, 1'b0, a, b);
            end
         end
      end
      @(negedge clock);
      totalCnt++;
      if (sb.size() !== 0) $display("[TB] FAIL sbDrain: got %0d left expected 0", sb.size()); else passCnt++;
   endtask

   initial begin
      reset          = 1'b0;
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      bus.op_a       = '0;
      bus.op_b       = '0;
      bus.abort      = 1'b0;
      bus.hi_we      = 1'b0;
      bus.lo_we      = 1'b0;
      bus.wdata      = '0;
`ifdef MULDIV_UNSIGNED_EN
      bus.is_unsigned = 1'b0;
`endif
      modelHi = '0;
      modelLo = '0;
      @(negedge clock);
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_abort();
      test_overflow_reset();
      test_both_start_lo_we();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the HI/LO multiply/divide resource of the multicycle MIPS datapath. Accepts one-cycle start pulses from the main control unit, runs iterative signed multiply (shift-add) or signed restoring divide on the A/B register operands, and writes HI/LO. Raises busy so control can stall mfhi/mflo and new mult/div. Flags divide-by-zero to the exception logic.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start_mult  in  1  one-cycle pulse: begin HI:LO = op_a * op_b
start_div  in  1  one-cycle pulse: begin LO = op_a / op_b, HI = op_a % op_b
op_a  in  WIDTH  operand A (RegA), sampled in start cycle only
op_b  in  WIDTH  operand B (RegB), sampled in start cycle only
abort  in  1  exception flush: cancel operation in flight
hi_we  in  1  direct write of HI (mthi)
lo_we  in  1  direct write of LO (mtlo)
wdata  in  WIDTH  data for hi_we/lo_we
busy  out  1  operation in flight
done  out  1  one-cycle pulse: HI/LO updated by completed op
div_zero  out  1  one-cycle pulse: divide with op_b == 0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, busy=0, done=0, div_zero=0, hi=0, lo=0, internal operand/accumulator regs 0. Reset mid-operation discards it.
- States: IDLE, MUL_ITER, DIV_ITER, FIX, DONE, DZ.
- IDLE: start_mult in cycle T -> capture |op_a|,|op_b| and result sign, counter=WIDTH-1, enter MUL_ITER. start_div -> same capture plus dividend sign, enter DIV_ITER; if op_b==0 enter DZ instead.
- start_mult and start_div both high: mult wins, div dropped silently.
- start_* while not IDLE: ignored, no effect on the op in flight.
- MUL_ITER/DIV_ITER: one bit per cycle, counter decrements; at counter==0 go to FIX. Exactly WIDTH iteration cycles.
- FIX: apply two's-complement sign correction (mult: product negated if signs differ; div: quotient negated if signs differ, remainder takes dividend sign). Go to DONE.
- DONE: hi/lo take results on entry edge; done=1 for this cycle, busy=0; next state IDLE (a start in the DONE cycle is accepted as in IDLE).
- Latency: start in cycle T -> busy=1 in T+1..T+WIDTH+1, done=1 and new hi/lo visible in T+WIDTH+2 (T+34 for WIDTH=32).
- DZ: div_zero=1 and busy=1 for cycle T+1 only; hi/lo unchanged; no done; IDLE in T+2.
- Overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (deterministic, no flag).
- abort high in any non-IDLE state: IDLE next edge, busy=0, hi/lo unchanged, no done/div_zero. abort in IDLE: no effect. abort and start same IDLE cycle: start ignored.
- hi_we/lo_we: honoured only when busy=0 (IDLE or DONE cycle); register updates next edge. Ignored while busy. In DONE cycle, the result write already happened; hi_we/lo_we then overwrite next edge. Write and start in same IDLE cycle: write applied, result later overwrites.
- All outputs registered; no combinational path input->output.

Optional Feature:
MULDIV_UNSIGNED_EN: adds input is_unsigned (1 bit, sampled with start_*) supporting multu/divu: operands used raw, FIX does no sign correction, overflow case not special. Without macro: port absent, all ops signed.

Decomposition:
- Package muldiv_pkg: state encoding constants (IDLE..DZ), WIDTH default, MIN_INT constant, op-select constants (OP_MULT, OP_DIV).
- One sub-module: muldiv_iter_counter (load WIDTH-1, decrement, last flag, clear on abort/reset).

Test Plan:
- start_mult, op_a=7, op_b=0xFFFFFFFD (-3) at T -> done in T+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high T+1..T+33.
- start_div, op_a=0xFFFFFFF9 (-7), op_b=2 -> done T+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- hi=0x1234 preloaded via hi_we; start_div op_a=5, op_b=0 -> div_zero pulse T+1 only, no done, hi=0x1234 held, busy=0 at T+2.
- start_mult 3*4, then start_div and hi_we pulsed at T+5, abort at T+10 -> idle at T+11, no done, hi/lo = pre-op values.
- start_div op_a=0x80000000, op_b=0xFFFFFFFF -> done T+34, lo=0x80000000, hi=0; then reset=0 mid-op of a new mult -> hi=lo=0, busy=0 immediately.
- start_mult and start_div both high, op_a=6, op_b=7 -> mult only, lo=42, hi=0; lo_we with wdata=9 in done cycle -> lo=9 next cycle.
